// File: rtl/des_key_scheduler_pkg.sv
// Shared DES key-schedule definitions: widths, rotation schedule,
// the PC1/PC2 permutation tables, the scheduler state enum and the
// half-key rotation and key-load permutation helpers.
// Bit numbering: DES bit n (1 = MSB) of a W-bit vector sits at index W-n.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 2 * HALF_W;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Rotation per round; entry r-1 holds the shift of DES round r. Sums to 28.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Key-load permutation: output bit i+1 takes key bit PC1_TAB[i].
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Subkey compression: subkey bit i+1 takes C/D bit PC2_TAB[i].
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Circular rotation of one 28-bit half by 0, 1 or 2 places.
  function automatic logic [HALF_W-1:0] rotate_half(
    input logic [HALF_W-1:0] v,
    input logic [1:0]        amt,
    input logic              right
  );
    logic [HALF_W-1:0] r;
    r = v;
    case (amt)
      2'd1:    r = right ? {v[0], v[HALF_W-1:1]}   : {v[HALF_W-2:0], v[HALF_W-1]};
      2'd2:    r = right ? {v[1:0], v[HALF_W-1:2]} : {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Key-load permutation; parity bits 8,16,..,64 are dropped.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < CD_W; i++) begin
      r[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_key_scheduler_if.sv
// Control and subkey handshake bundle between the key scheduler (master
// side: produces subkeys) and the round datapath (slave side: consumes them).
interface des_key_scheduler_if;
  import des_pkg::*;

  logic                start;
  logic                decrypt;
  logic [KEY_W-1:0]    key;
  logic                abort;
  logic [SUBKEY_W-1:0] subkey;
  logic                subkey_valid;
  logic                subkey_ready;
  logic [3:0]          round;
  logic                busy;
  logic                done;

  modport master (
    input  start, decrypt, key, abort, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );

  modport slave (
    output start, decrypt, key, abort, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );
endinterface

// File: rtl/des_key_scheduler_pc2.sv
// Combinational 56->48 PC2 compression of the concatenated C/D halves.
module des_key_scheduler_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     i_cd,
  output logic [SUBKEY_W-1:0] o_subkey
);

  for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_bit
    assign o_subkey[SUBKEY_W-1-gi] = i_cd[6'(CD_W - PC2_TAB[gi])];
  end

endmodule

// File: rtl/des_key_scheduler.sv
// DES key scheduler: latches PC1(key) into C/D, then emits the 16 round
// subkeys one per accepted transfer, in encrypt or decrypt order. Only the
// current C/D pair is kept; each subkey is derived when the previous one is
// consumed, so no subkey store is needed.
module des_key_scheduler
  import des_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  des_key_scheduler_if.master  bus
);

  localparam logic [3:0] LAST_ROUND = 4'd15;

  state_t              r_state, w_state_next;
  logic                r_mode, w_mode_next;
  logic [HALF_W-1:0]   r_c, r_d, w_c_next, w_d_next;
  logic [HALF_W-1:0]   w_c_rot, w_d_rot;
  logic [SUBKEY_W-1:0] r_subkey, w_subkey_next, w_pc2_out;
  logic                r_valid, w_valid_next;
  logic [3:0]          r_round, w_round_next;
  logic                r_done, w_done_next;
  logic [1:0]          w_rot_amt;
  logic                w_rot_right;
  logic                w_xfer;

  assign w_xfer  = r_valid & bus.subkey_ready;
  assign w_c_rot = rotate_half(r_c, w_rot_amt, w_rot_right);
  assign w_d_rot = rotate_half(r_d, w_rot_amt, w_rot_right);

  des_key_scheduler_pc2 u_pc2 (
    .i_cd     ({w_c_rot, w_d_rot}),
    .o_subkey (w_pc2_out)
  );

  // Rotation that produces the next subkey. Decrypt starts from C16/D16 = C0/D0
  // and walks backwards, undoing round 16, 15, ... with right rotations.
  always_comb begin
    w_rot_amt   = 2'd0;
    w_rot_right = 1'b0;
    if (r_state == ST_LOAD) begin
      w_rot_amt = r_mode ? 2'd0 : SHIFT[0];
    end else if (r_mode) begin
      w_rot_amt   = SHIFT[LAST_ROUND - r_round];
      w_rot_right = 1'b1;
    end else begin
      w_rot_amt = SHIFT[r_round + 4'd1];
    end
  end

  // Next-state and next-output decode; abort wins over a simultaneous transfer.
  always_comb begin
    w_state_next  = r_state;
    w_mode_next   = r_mode;
    w_c_next      = r_c;
    w_d_next      = r_d;
    w_subkey_next = r_subkey;
    w_valid_next  = r_valid;
    w_round_next  = r_round;
    w_done_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_mode_next            = bus.decrypt;
          {w_c_next, w_d_next}   = pc1(bus.key);
          w_state_next           = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          w_state_next  = ST_IDLE;
          w_valid_next  = 1'b0;
          w_round_next  = 4'd0;
          w_subkey_next = '0;
        end else begin
          w_c_next      = w_c_rot;
          w_d_next      = w_d_rot;
          w_subkey_next = w_pc2_out;
          w_valid_next  = 1'b1;
          w_round_next  = 4'd0;
          w_state_next  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.abort) begin
          w_state_next  = ST_IDLE;
          w_valid_next  = 1'b0;
          w_round_next  = 4'd0;
          w_subkey_next = '0;
        end else if (w_xfer) begin
          if (r_round == LAST_ROUND) begin
            w_valid_next = 1'b0;
            w_done_next  = 1'b1;
            w_round_next = 4'd0;
            w_state_next = ST_IDLE;
          end else begin
            w_c_next      = w_c_rot;
            w_d_next      = w_d_rot;
            w_subkey_next = w_pc2_out;
            w_round_next  = r_round + 4'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mode   <= 1'b0;
      r_c      <= '0;
      r_d      <= '0;
      r_subkey <= '0;
      r_valid  <= 1'b0;
      r_round  <= 4'd0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_mode   <= w_mode_next;
      r_c      <= w_c_next;
      r_d      <= w_d_next;
      r_subkey <= w_subkey_next;
      r_valid  <= w_valid_next;
      r_round  <= w_round_next;
      r_done   <= w_done_next;
    end
  end

  assign bus.subkey       = r_subkey;
  assign bus.subkey_valid = r_valid;
  assign bus.round        = r_round;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.done         = r_done;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler. The reference model derives each
// subkey straight from the DES definition: C_i/D_i are C0/D0 rotated by the
// cumulative shift count, then PC2; decrypt order is the reversed list.
module tb_des_key_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  des_key_scheduler_if bus ();

  des_key_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables (FIPS 46-3).
  int M_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int M_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int M_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] exp_keys [16];
  logic [27:0] exp_c0, exp_d0;
  logic [47:0] obs_first, obs_last;
  logic [27:0] obs_c0, obs_d0;

  task automatic build_model(input logic [63:0] k, input logic dec);
    logic [55:0] cd0, cdi;
    logic [47:0] ks [16];
    int total;
    for (int i = 1; i <= 56; i++) cd0[6'(56 - i)] = k[6'(64 - M_PC1[i-1])];
    exp_c0 = cd0[55:28];
    exp_d0 = cd0[27:0];
    total = 0;
    for (int r = 1; r <= 16; r++) begin
      total += M_SHIFT[r-1];
      for (int j = 1; j <= 28; j++) begin
        cdi[6'(56 - j)] = cd0[6'(56 - (((j - 1 + total) % 28) + 1))];
        cdi[6'(28 - j)] = cd0[6'(28 - (((j - 1 + total) % 28) + 1))];
      end
      for (int b = 1; b <= 48; b++) ks[r-1][6'(48 - b)] = cdi[6'(56 - M_PC2[b-1])];
    end
    for (int idx = 0; idx < 16; idx++) exp_keys[idx] = dec ? ks[15-idx] : ks[idx];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full schedule with start issued now; optional random stalls and a stray
  // start (with a different key) while subkeys are being emitted.
  task automatic run_schedule(input logic [63:0] k, input logic dec,
                              input bit stalls, input bit inject_start);
    int n_stall;
    build_model(k, dec);
    bus.key = k; bus.decrypt = dec; bus.start = 1'b1; bus.subkey_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.key = {$urandom, $urandom};
    bus.decrypt = 1'($urandom_range(0, 1));
    n_checks++;
    if ({bus.busy, bus.subkey_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL load_cycle: busy/valid=%b expected 10", {bus.busy, bus.subkey_valid});
    end
    obs_c0 = dut.r_c; obs_d0 = dut.r_d;
    n_checks++;
    if ({obs_c0, obs_d0} !== {exp_c0, exp_d0}) begin
      n_errors++;
      $display("FAIL pc1_load: C/D=%h/%h expected %h/%h", obs_c0, obs_d0, exp_c0, exp_d0);
    end
    tick();
    for (int idx = 0; idx < 16; idx++) begin
      n_stall = stalls ? int'($urandom_range(0, 5)) : 0;
      for (int s = 0; s < n_stall; s++) begin
        bus.subkey_ready = 1'b0;
        n_checks++;
        if ({bus.subkey_valid, bus.round, bus.subkey} !== {1'b1, idx[3:0], exp_keys[idx]}) begin
          n_errors++;
          $display("FAIL stall_hold: v=%b round=%0d key=%h expected v=1 round=%0d key=%h",
                   bus.subkey_valid, bus.round, bus.subkey, idx, exp_keys[idx]);
        end
        tick();
      end
      bus.subkey_ready = 1'b1;
      if (inject_start && idx == 5) begin
        bus.start = 1'b1; bus.key = ~k; bus.decrypt = ~dec;
      end
      n_checks++;
      if ({bus.subkey_valid, bus.round, bus.subkey, bus.done, bus.busy} !==
          {1'b1, idx[3:0], exp_keys[idx], 1'b0, 1'b1}) begin
        n_errors++;
        $display("FAIL transfer: v=%b round=%0d key=%h done=%b busy=%b expected v=1 round=%0d key=%h done=0 busy=1",
                 bus.subkey_valid, bus.round, bus.subkey, bus.done, bus.busy, idx, exp_keys[idx]);
      end
      $display("xfer mode=%0d round=%0d subkey=%h stalls=%0d", dec, bus.round, bus.subkey, n_stall);
      if (idx == 0)  obs_first = bus.subkey;
      if (idx == 15) obs_last  = bus.subkey;
      tick();
      bus.start = 1'b0;
    end
    bus.subkey_ready = 1'b0;
    n_checks++;
    if ({bus.done, bus.busy, bus.subkey_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL done_pulse: done/busy/valid=%b expected 100",
               {bus.done, bus.busy, bus.subkey_valid});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.decrypt = 1'b0; bus.key = '0; bus.abort = 1'b0; bus.subkey_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.subkey, bus.subkey_valid, bus.round, bus.busy, bus.done, dut.r_c, dut.r_d} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: key=%h v=%b round=%0d busy=%b done=%b C=%h D=%h expected all zero",
               bus.subkey, bus.subkey_valid, bus.round, bus.busy, bus.done, dut.r_c, dut.r_d);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.busy, bus.subkey_valid, bus.done} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_after_reset: busy/valid/done=%b expected 000",
               {bus.busy, bus.subkey_valid, bus.done});
    end
  endtask

  task automatic test_encrypt_vector();
    run_schedule(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({obs_c0, obs_d0} !== {28'hF0CCAAF, 28'h556678F}) begin
      n_errors++;
      $display("FAIL enc_c0d0: %h/%h expected F0CCAAF/556678F", obs_c0, obs_d0);
    end
    n_checks++;
    if (obs_first !== 48'h1B02EFFC7072) begin
      n_errors++;
      $display("FAIL enc_k1: %h expected 1B02EFFC7072", obs_first);
    end
    n_checks++;
    if (obs_last !== 48'hCB3D8B0E17F5) begin
      n_errors++;
      $display("FAIL enc_k16: %h expected CB3D8B0E17F5", obs_last);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL done_one_cycle: done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_decrypt_vector();
    run_schedule(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_first !== 48'hCB3D8B0E17F5) begin
      n_errors++;
      $display("FAIL dec_first: %h expected CB3D8B0E17F5", obs_first);
    end
    n_checks++;
    if (obs_last !== 48'h1B02EFFC7072) begin
      n_errors++;
      $display("FAIL dec_last: %h expected 1B02EFFC7072", obs_last);
    end
    tick();
  endtask

  task automatic test_stalls();
    run_schedule(64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0);
    tick();
    run_schedule({$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_start_during_emit();
    run_schedule({$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_start: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_abort();
    bus.key = {$urandom, $urandom}; bus.decrypt = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.subkey_ready = 1'b1;
    repeat (7) tick();
    n_checks++;
    if ({bus.subkey_valid, bus.round} !== {1'b1, 4'd7}) begin
      n_errors++;
      $display("FAIL abort_reach: v=%b round=%0d expected v=1 round=7", bus.subkey_valid, bus.round);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.subkey_ready = 1'b0;
    $display("abort at round=7");
    n_checks++;
    if ({bus.subkey_valid, bus.busy, bus.done, bus.round, bus.subkey} !== '0) begin
      n_errors++;
      $display("FAIL abort_state: v=%b busy=%b done=%b round=%0d key=%h expected all zero",
               bus.subkey_valid, bus.busy, bus.done, bus.round, bus.subkey);
    end
    tick();
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL abort_no_done: done/busy=%b expected 00", {bus.done, bus.busy});
    end
    run_schedule({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_async_reset();
    bus.key = {$urandom, $urandom}; bus.decrypt = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.subkey_ready = 1'b1;
    repeat (10) tick();
    n_checks++;
    if ({bus.subkey_valid, bus.round} !== {1'b1, 4'd10}) begin
      n_errors++;
      $display("FAIL rst_reach: v=%b round=%0d expected v=1 round=10", bus.subkey_valid, bus.round);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("async reset at round=10");
    n_checks++;
    if ({bus.subkey, bus.subkey_valid, bus.round, bus.busy, bus.done} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: key=%h v=%b round=%0d busy=%b done=%b expected all zero",
               bus.subkey, bus.subkey_valid, bus.round, bus.busy, bus.done);
    end
    bus.subkey_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.busy, bus.subkey_valid, bus.done} !== 3'b000) begin
      n_errors++;
      $display("FAIL no_resume: busy/valid/done=%b expected 000", {bus.busy, bus.subkey_valid, bus.done});
    end
    run_schedule(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_first !== 48'h1B02EFFC7072) begin
      n_errors++;
      $display("FAIL post_reset_k1: %h expected 1B02EFFC7072", obs_first);
    end
    tick();
  endtask

  // Second start lands in the done cycle of the first schedule.
  task automatic test_back_to_back();
    run_schedule({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    run_schedule({$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 4; n++) begin
      run_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_encrypt_vector();
    test_decrypt_vector();
    test_stalls();
    test_start_during_emit();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random_keys();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_key_scheduler.md
# des_key_scheduler

Sequences the DES key schedule: latches a 64-bit key through the existing PC1 permutation, then produces the 16 48-bit round subkeys one at a time using per-round rotation of the 28-bit C/D halves followed by PC2. It sits between the key input and the round datapath. It delivers subkeys over a valid/ready handshake in encrypt order (K1..K16) or decrypt order (K16..K1). A subkey is produced only when the round datapath is ready for it, so no 768-bit subkey store is needed.

## Interface
- No parameters; widths are fixed by DES.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a new schedule; sampled only in IDLE.
- decrypt  in  1  sampled with start; 0 selects K1..K16, 1 selects K16..K1.
- key  in  [1:64]  DES key, MSB-first numbering; parity bits ignored by PC1; sampled with start.
- abort  in  1  synchronous cancel of a running schedule.
- subkey  out  [1:48]  current round subkey.
- subkey_valid  out  1  subkey holds a valid round key.
- subkey_ready  in  1  consumer accepts subkey when high together with subkey_valid.
- round  out  [3:0]  index of the presented subkey in delivery order, 0..15.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the 16th transfer.

## Operation
- States: IDLE, LOAD, EMIT.
- IDLE
  - Accepts start, latches decrypt into mode_q, loads {C,D} <= PC1(key), then goes to LOAD.
  - start is ignored in every other state.
- LOAD
  - Computes the first subkey, sets subkey_valid=1 and round=0, then goes to EMIT.
  - Encrypt: rotate C and D left by SHIFT[1].
  - Decrypt: no rotation, because C16/D16 equal C0/D0.
- EMIT
  - subkey, round and subkey_valid are held stable while subkey_ready=0.
  - On a transfer with round<15: rotate C/D, register PC2 of the new C/D, round+1.
  - Encrypt round r (1-based) rotates left by SHIFT[r].
  - Decrypt delivery step r≥2 rotates right by SHIFT[18-r].
  - On a transfer with round=15: subkey_valid=0, done=1 for one cycle, return to IDLE.
- SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; the sum is 28, so the halves are back at C0/D0 after 16 rounds.
- All rotations are 28-bit circular and applied independently to C and D.
- abort
  - In LOAD or EMIT: next edge goes to IDLE with subkey_valid=0 and round=0; no done pulse.
  - abort has priority over a simultaneous transfer.
- Changes to key or decrypt after start are ignored until the next start.
- Reset and abort clear subkey; it is otherwise only written on valid updates.

## Timing
- Reset values: subkey=0, subkey_valid=0, round=0, busy=0, done=0, state=IDLE, C=D=0.
- rst_n low mid-schedule clears everything immediately; the schedule does not resume.
- start sampled at edge E0; first subkey_valid=1 after edge E1, i.e. 2 cycles of latency.
- With subkey_ready held high: one subkey per cycle, 16 consecutive valid cycles, done in the cycle after the last transfer.
- done and busy=0 fall in the same cycle. A new start may be sampled in that cycle; back-to-back schedules cost 2 idle cycles.
- Outputs are registered; there is no combinational path from subkey_ready to subkey or subkey_valid.

## Structure
- Package des_pkg holds:
  - the SHIFT schedule constant array;
  - the widths KEY_W=64, HALF_W=28, SUBKEY_W=48;
  - the state enum.
- Reuse existing PC1 for the key load. Add sub-module PC2, a combinational 56→48 permutation per FIPS 46-3, shared later by any unrolled datapath.
- A rotation helper function for left/right rotation by 1 or 2 goes in des_pkg.

## Test plan
- Encrypt, key=133457799BBCDFF1, ready=1:
  - after load, C0=F0CCAAF and D0=556678F;
  - round0 subkey=1B02EFFC7072, round15 subkey=CB3D8B0E17F5;
  - 16 contiguous valid cycles; done one cycle after the last transfer.
- Decrypt with the same key: round0 subkey=CB3D8B0E17F5, round15 subkey=1B02EFFC7072; the full sequence equals the exact reverse of the encrypt run.
- Random ready stalls (ready low 0–5 cycles) → subkey and round stable while stalled; the sequence is identical to the no-stall run; exactly 16 transfers.
- start pulsed during EMIT with a different key → ignored; the output sequence is unchanged.
- abort at round=7 with ready=1 → next cycle valid=0, busy=0, no done. A subsequent start gives a correct full sequence.
- rst_n asserted asynchronously mid-cycle at round=10 → all outputs go to reset values immediately without waiting for clk. A start after release gives a correct K1.
